// File: rtl/frac_ena_gen_pkg.sv
// frac_ena_pkg: constants and helpers used by the fractional enable generator.
// The sum carries one extra bit above the ratio width. A clamped numerator
// never exceeds the denominator, so that extra bit is enough to hold the sum.
package frac_ena_pkg;

  // Extra bits the accumulator sum needs above WIDTH.
  localparam int unsigned FRAC_SUM_XTRA = 1;

  // Widest ratio the clamp helper handles. WIDTH must not exceed this.
  localparam int unsigned FRAC_MAX_W = 32;

  // Width of the optional pulse statistics counter.
  localparam int unsigned STATS_CNT_W = 32;

  // Effective numerator: a ratio at or above 1 becomes exactly 1 (num == den).
  // A pulse then fires on every run cycle and the phase stays at 0.
  function automatic logic [FRAC_MAX_W-1:0] clamp_num(
    input logic [FRAC_MAX_W-1:0] num,
    input logic [FRAC_MAX_W-1:0] den
  );
    return (num > den) ? den : num;
  endfunction

endpackage

// File: rtl/frac_ena_gen_cfg.sv
// frac_ena_cfg: ratio shadow registers for frac_ena_gen.
// Captures a new num/den on sload. sclear has priority over sload, so a
// simultaneous sclear leaves the ratio untouched. This block also flags a zero
// denominator and presents the clamped numerator to the accumulator core.
module frac_ena_cfg
  import frac_ena_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned INIT_NUM = 1,
  parameter int unsigned INIT_DEN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_sclear,
  input  logic             i_sload,
  input  logic [WIDTH-1:0] i_num,
  input  logic [WIDTH-1:0] i_den,
  output logic [WIDTH-1:0] o_eff_num,
  output logic [WIDTH-1:0] o_den,
  output logic             o_cfg_err
);

  logic [WIDTH-1:0] r_num;
  logic [WIDTH-1:0] r_den;
  logic             r_cfg_err;
  logic             w_load;

  assign w_load = i_sload && !i_sclear;

  // Ratio registers: reload on sload only. The ratio reverts to the init values on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num     <= WIDTH'(INIT_NUM);
      r_den     <= WIDTH'(INIT_DEN);
      r_cfg_err <= (INIT_DEN == 0);
    end else if (w_load) begin
      r_num     <= i_num;
      r_den     <= i_den;
      r_cfg_err <= (i_den == '0);
    end
  end

  assign o_eff_num = WIDTH'(clamp_num(FRAC_MAX_W'(r_num), FRAC_MAX_W'(r_den)));
  assign o_den     = r_den;
  assign o_cfg_err = r_cfg_err;

endmodule

// File: rtl/frac_ena_gen.sv
// frac_ena_gen: fractional-rate enable generator (Bresenham accumulator).
// ena_out emits single-cycle pulses at an average rate of num/den clocks and
// never drifts. acc is the current phase, in the range 0..den-1.
// Optional build macro FRAC_ENA_STATS_EN: adds a 32-bit pulse_cnt output.
module frac_ena_gen
  import frac_ena_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned INIT_NUM = 1,
  parameter int unsigned INIT_DEN = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic                   sclear,
  input  logic                   sload,
  input  logic [WIDTH-1:0]       sdata_num,
  input  logic [WIDTH-1:0]       sdata_den,
  output logic                   ena_out,
  output logic [WIDTH-1:0]       acc,
  output logic                   cfg_err
`ifdef FRAC_ENA_STATS_EN
  ,
  output logic [STATS_CNT_W-1:0] pulse_cnt
`endif
);

  localparam int unsigned SUM_W = WIDTH + FRAC_SUM_XTRA;

  logic [WIDTH-1:0] w_eff_num;
  logic [WIDTH-1:0] w_den;
  logic             w_cfg_err;
  logic [SUM_W-1:0] w_sum;
  logic             w_ovf;
  logic [WIDTH-1:0] w_wrap;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_ena_next;
  logic [WIDTH-1:0] r_acc;
  logic             r_ena;

  frac_ena_cfg #(
    .WIDTH    (WIDTH),
    .INIT_NUM (INIT_NUM),
    .INIT_DEN (INIT_DEN)
  ) u_cfg (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_sclear  (sclear),
    .i_sload   (sload),
    .i_num     (sdata_num),
    .i_den     (sdata_den),
    .o_eff_num (w_eff_num),
    .o_den     (w_den),
    .o_cfg_err (w_cfg_err)
  );

  // Next phase and pulse. Priority is sclear/sload, then run (with a valid ratio), else hold.
  always_comb begin
    w_sum      = {1'b0, r_acc} + {1'b0, w_eff_num};
    w_ovf      = (w_sum >= {1'b0, w_den});
    w_wrap     = WIDTH'(w_sum - {1'b0, w_den});
    w_acc_next = r_acc;
    w_ena_next = 1'b0;
    if (sclear || sload) begin
      w_acc_next = '0;
    end else if (run && !w_cfg_err) begin
      if (w_ovf) begin
        w_acc_next = w_wrap;
        w_ena_next = 1'b1;
      end else begin
        w_acc_next = w_sum[WIDTH-1:0];
      end
    end
  end

  // Phase and pulse registers. A pulse lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ena <= 1'b0;
    end else begin
      r_acc <= w_acc_next;
      r_ena <= w_ena_next;
    end
  end

  assign ena_out = r_ena;
  assign acc     = r_acc;
  assign cfg_err = w_cfg_err;

`ifdef FRAC_ENA_STATS_EN
  logic [STATS_CNT_W-1:0] r_pulse_cnt;

  // Pulse counter. It steps together with the ena_out register and wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pulse_cnt <= '0;
    end else if (sclear || sload) begin
      r_pulse_cnt <= '0;
    end else if (w_ena_next) begin
      r_pulse_cnt <= r_pulse_cnt + 1'b1;
    end
  end

  assign pulse_cnt = r_pulse_cnt;
`endif

endmodule
